// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM encoding, ROM word fields, counter widths.
// Pure declarations, no logic; no flow control.
package melody_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_NOTE   = 3'd3,
        ST_GAP    = 3'd4,
        ST_PAUSED = 3'd5,
        ST_FINISH = 3'd6
    } state_t;

    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 4;
    localparam int NOTE_MSB = 3;
    localparam int NOTE_LSB = 0;

    localparam logic [3:0] END_DUR   = 4'd0;
    localparam logic [3:0] REST_NOTE = 4'd0;

    function automatic int presc_w(input int clk_hz, input int beat_hz);
        int div;
        div = clk_hz / beat_hz;
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    function automatic int gap_w(input int gap_cyc);
        return (gap_cyc < 2) ? 1 : $clog2(gap_cyc + 1);
    endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Beat prescaler: 1-clk tick every DIV enabled clocks; holds its count while enable is low.
// Tick is combinational from the count register; sync clear has priority over enable; no backpressure.
module beat_tick_gen #(
    parameter int DIV = 10,
    parameter int CW  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Plays {DUR,NOTE} words from a sync note ROM as tone indices, each followed by a silent gap.
// START -> INX after 3 clks (ROM read + input retime + decode); keys are pulses, no backpressure.
// MELODY_LOOP_EN defined: the song restarts from address 0 after DONE instead of finishing.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_HZ  = 12_000_000,
    parameter int BEAT_HZ = 4,
    parameter int ADDR_W  = 8,
    parameter int GAP_CYC = 240_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              stop_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    output logic [3:0]        inx_o,
    output logic              beat_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DIV = CLK_HZ / BEAT_HZ;
    localparam int PW  = presc_w(CLK_HZ, BEAT_HZ);
    localparam int GW  = gap_w(GAP_CYC);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_CYC - 1);

    state_t            state_q, state_d;
    state_t            resume_q, resume_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        inx_q, inx_d;
    logic [3:0]        note_q, note_d;
    logic [3:0]        beats_q, beats_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              beat_q, beat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fetch_ph_q, fetch_ph_d;
    logic [7:0]        rom_q;

    logic              tick;
    logic              tick_clr;
    logic              song_end;
    logic [3:0]        rom_dur;
    logic [3:0]        rom_note;

    assign rom_dur  = rom_q[DUR_MSB:DUR_LSB];
    assign rom_note = rom_q[NOTE_MSB:NOTE_LSB];

    beat_tick_gen #(
        .DIV (DIV),
        .CW  (PW)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q == ST_NOTE),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        addr_d     = addr_q;
        inx_d      = inx_q;
        note_d     = note_q;
        beats_d    = beats_q;
        gap_d      = gap_q;
        beat_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fetch_ph_d = 1'b0;
        tick_clr   = 1'b0;
        song_end   = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            // Two cycles: ROM read latency, then the rom_q retiming register.
            ST_FETCH: begin
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (rom_dur == END_DUR) begin
                    song_end = 1'b1;
                end else begin
                    inx_d    = rom_note;
                    note_d   = rom_note;
                    beats_d  = rom_dur;
                    tick_clr = 1'b1;
                    state_d  = ST_NOTE;
                end
            end
            ST_NOTE: begin
                if (tick) begin
                    beat_d = 1'b1;
                    if (beats_q == 4'd1) begin
                        inx_d   = REST_NOTE;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        beats_d = beats_q - 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (addr_q == ADDR_LAST) begin
                        song_end = 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_PAUSED: begin
                if (pause_i) begin
                    state_d = resume_q;
                    inx_d   = (resume_q == ST_NOTE) ? note_q : REST_NOTE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (song_end) begin
            done_d = 1'b1;
            inx_d  = REST_NOTE;
            addr_d = '0;
`ifdef MELODY_LOOP_EN
            state_d = ST_FETCH;
`else
            state_d = ST_FINISH;
            busy_d  = 1'b0;
`endif
        end

        // The pause clock itself still counts as played time, so the remaining time is exact on resume.
        if (pause_i && (state_q == ST_NOTE || state_q == ST_GAP) &&
            (state_d == ST_NOTE || state_d == ST_GAP)) begin
            resume_d = state_d;
            state_d  = ST_PAUSED;
            inx_d    = REST_NOTE;
            beat_d   = 1'b0;
        end

        if (stop_i) begin
            state_d = ST_IDLE;
            inx_d   = REST_NOTE;
            addr_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            beat_d  = 1'b0;
            beats_d = '0;
            gap_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            resume_q   <= ST_NOTE;
            addr_q     <= '0;
            inx_q      <= '0;
            note_q     <= '0;
            beats_q    <= '0;
            gap_q      <= '0;
            beat_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fetch_ph_q <= 1'b0;
            rom_q      <= '0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            addr_q     <= addr_d;
            inx_q      <= inx_d;
            note_q     <= note_d;
            beats_q    <= beats_d;
            gap_q      <= gap_d;
            beat_q     <= beat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fetch_ph_q <= fetch_ph_d;
            rom_q      <= rom_data_i;
        end
    end

    assign rom_addr_o = addr_q;
    assign inx_o      = inx_q;
    assign beat_o     = beat_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench: 10 clks/beat, 2-clk gap; DUT a has an 8-bit address, DUT b a 2-bit address.
module tb_melody_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, pause_a = 1'b0, stop_a = 1'b0;
    logic [7:0] addr_a;
    logic [7:0] rom_dat_a;
    logic [3:0] inx_a;
    logic       beat_a, busy_a, done_a;

    logic       start_b = 1'b0;
    logic [1:0] addr_b;
    logic [7:0] rom_dat_b;
    logic [3:0] inx_b;
    logic       beat_b, busy_b, done_b;

    logic [7:0] rom_a [256];
    logic [7:0] rom_b [4];

    always @(posedge clk) rom_dat_a <= rom_a[addr_a];
    always @(posedge clk) rom_dat_b <= rom_b[addr_b];

    melody_sequencer #(.CLK_HZ(40), .BEAT_HZ(4), .ADDR_W(8), .GAP_CYC(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .pause_i(pause_a), .stop_i(stop_a),
        .rom_addr_o(addr_a), .rom_data_i(rom_dat_a), .inx_o(inx_a), .beat_o(beat_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    melody_sequencer #(.CLK_HZ(40), .BEAT_HZ(4), .ADDR_W(2), .GAP_CYC(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .pause_i(1'b0), .stop_i(1'b0),
        .rom_addr_o(addr_b), .rom_data_i(rom_dat_b), .inx_o(inx_b), .beat_o(beat_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    int passed = 0;
    int total  = 0;
    int beats  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] inx_of(input bit b);
        return b ? inx_b : inx_a;
    endfunction

    // Counts consecutive samples with INX == v; beat pulses seen on the way are accumulated.
    task automatic run_len(input bit b, input logic [3:0] v, output int n);
        n = 0;
        while (inx_of(b) === v && n < 300) begin
            n++;
            step(1);
            beats += b ? int'(beat_b) : int'(beat_a);
        end
    endtask

    task automatic wait_inx(input bit b, output int n);
        n = 0;
        while (inx_of(b) === 4'd0 && n < 50) begin
            n++;
            step(1);
        end
    endtask

    task automatic wait_done(input bit b, output int n);
        n = 0;
        while ((b ? done_b : done_a) !== 1'b1 && n < 50) begin
            n++;
            step(1);
        end
    endtask

    initial begin
        int n;
        int bad;

        for (int i = 0; i < 256; i++) rom_a[i] = 8'h00;
        rom_a[0] = 8'h25;
        rom_a[1] = 8'h15;
        rom_a[2] = 8'h00;
        rom_b[0] = 8'h11;
        rom_b[1] = 8'h12;
        rom_b[2] = 8'h13;
        rom_b[3] = 8'h14;

        step(2);
        chk("rst_addr", addr_a, 0);
        chk("rst_inx", inx_a, 0);
        chk("rst_beat", beat_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        rst_n = 1'b1;
        step(1);

        // Song {0x25,0x15,end}: each inter-note silence is 2 gap clks plus 3 fetch clks.
        start_a = 1'b1; step(1); start_a = 1'b0;
        chk("t1_busy", busy_a, 1);
        chk("t1_addr0", addr_a, 0);
        chk("t1_inx0", inx_a, 0);
        wait_inx(0, n);
        chk("t1_latency", n, 3);
        beats = 0;
        run_len(0, 4'd5, n);
        chk("t1_note1_len", n, 20);
        run_len(0, 4'd0, n);
        chk("t1_gap_len", n, 5);
        chk("t1_addr1", addr_a, 1);
        run_len(0, 4'd5, n);
        chk("t1_note2_len", n, 10);
        wait_done(0, n);
        chk("t1_done_delay", n, 5);
        chk("t1_busy_end", busy_a, 0);
        chk("t1_addr_end", addr_a, 0);
        chk("t1_inx_end", inx_a, 0);
        chk("t1_beats", beats, 3);
        step(1);
        chk("t1_done_1clk", done_a, 0);

        // Pause on clock 7 of the 20-clk note, hold 30 clks, resume.
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_inx(0, n);
        chk("t2_latency", n, 3);
        step(6);
        chk("t2_inx_before", inx_a, 5);
        pause_a = 1'b1; step(1); pause_a = 1'b0;
        chk("t2_inx_paused", inx_a, 0);
        bad = 0;
        repeat (30) begin
            step(1);
            if (inx_a !== 4'd0 || beat_a !== 1'b0) bad++;
        end
        chk("t2_quiet_paused", bad, 0);
        pause_a = 1'b1; step(1); pause_a = 1'b0;
        chk("t2_inx_resumed", inx_a, 5);
        run_len(0, 4'd5, n);
        chk("t2_remaining", n, 13);

        // STOP with START on the same clock in the middle of note 2.
        run_len(0, 4'd0, n);
        chk("t3_gap_len", n, 5);
        step(3);
        stop_a = 1'b1; start_a = 1'b1; step(1); stop_a = 1'b0; start_a = 1'b0;
        chk("t3_inx", inx_a, 0);
        chk("t3_addr", addr_a, 0);
        chk("t3_busy", busy_a, 0);
        chk("t3_done", done_a, 0);
        bad = 0;
        repeat (20) begin
            step(1);
            if (done_a !== 1'b0 || busy_a !== 1'b0 || inx_a !== 4'd0) bad++;
        end
        chk("t3_stays_idle", bad, 0);

        // Asynchronous reset in the gap, then a fresh START replays from address 0.
        start_a = 1'b1; step(1); start_a = 1'b0;
        wait_inx(0, n);
        chk("t5_latency", n, 3);
        run_len(0, 4'd5, n);
        chk("t5_note1_len", n, 20);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy_a, 0);
        chk("t5_inx", inx_a, 0);
        chk("t5_addr", addr_a, 0);
        chk("t5_done", done_a, 0);
        chk("t5_beat", beat_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        start_a = 1'b1; step(1); start_a = 1'b0;
        chk("t5_restart_addr", addr_a, 0);
        wait_inx(0, n);
        chk("t5_restart_latency", n, 3);
        run_len(0, 4'd5, n);
        chk("t5_replay_len", n, 20);

        // 2-bit address, no end marker: four notes, then DONE when leaving the last gap.
        start_b = 1'b1; step(1); start_b = 1'b0;
        wait_inx(1, n);
        chk("t4_latency", n, 3);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("t4_inx_%0d", k), inx_b, k);
            chk($sformatf("t4_addr_%0d", k), addr_b, k - 1);
            run_len(1, 4'(k), n);
            chk($sformatf("t4_len_%0d", k), n, 10);
            if (k < 4) begin
                run_len(1, 4'd0, n);
                chk($sformatf("t4_gap_%0d", k), n, 5);
            end
        end
        wait_done(1, n);
        chk("t4_done_delay", n, 2);
        chk("t4_busy_end", busy_b, 0);
        chk("t4_addr_end", addr_b, 0);
        bad = 0;
        repeat (10) begin
            step(1);
            if (inx_b !== 4'd0 || busy_b !== 1'b0) bad++;
        end
        chk("t4_no_replay", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
